// File: rtl/pe_pkg.sv
// Shared types and widths for the PE cluster: FSM state encoding and the
// fixed int8 datapath / requantiser widths.
package pe_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned COEF_W  = 8;
  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_QUANT  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

endpackage

// File: rtl/pe_cluster_v3_if.sv
// Beat/result handshake bundle of the PE cluster: shared IFM beat, per-PE
// weights in, requantised int8 results out.
interface pe_cluster_v3_if
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned LANES  = 4
);

  logic                             in_valid;
  logic                             in_ready;
  logic [LANES*DATA_W-1:0]          ifm;
  logic [NUM_PE*LANES*DATA_W-1:0]   weight;
  logic [NUM_PE*DATA_W-1:0]         ofm;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    output in_valid, ifm, weight, out_ready,
    input  in_ready, ofm, out_valid
  );

  modport slave (
    input  in_valid, ifm, weight, out_ready,
    output in_ready, ofm, out_valid
  );

endinterface

// File: rtl/quad_pe_v3.sv
// One output-channel PE: LANES-wide int8 dot-product accumulator followed by
// a two-stage requantiser (multiply+round, then shift+saturate) and ofm register.
module quad_pe_v3
  import pe_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     acc_clr,
  input  logic                     acc_en,
  input  logic                     quant_mul,
  input  logic                     quant_out,
  input  logic [LANES*DATA_W-1:0]  ifm,
  input  logic [LANES*DATA_W-1:0]  weight,
  input  logic [COEF_W-1:0]        coef,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     relu_en,
  input  logic                     pe_en,
  output logic [DATA_W-1:0]        ofm
);

  localparam int unsigned PW = ACC_W + 9;

  logic signed [ACC_W-1:0]    acc_q, acc_d, dot;
  logic signed [PW-1:0]       prod_q, prod_d, rnd, shifted;
  logic signed [DATA_W-1:0]   ofm_q, ofm_d, sat;
  logic signed [DATA_W-1:0]   a, w;
  logic signed [2*DATA_W-1:0] p;

  always_comb begin
    dot = '0;
    a   = '0;
    w   = '0;
    p   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a   = ifm[l*DATA_W +: DATA_W];
      w   = weight[l*DATA_W +: DATA_W];
      p   = (2*DATA_W)'(a) * (2*DATA_W)'(w);
      dot = dot + ACC_W'(p);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + dot;
    end
  end

  // Stage 1: scale by the unsigned coefficient and add the round-half-up bias.
  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = PW'(1) << (shift - SHIFT_W'(1));
    end
    prod_d = prod_q;
    if (quant_mul) begin
      prod_d = PW'(acc_q) * PW'($signed({1'b0, coef})) + rnd;
    end
  end

  // Stage 2: arithmetic shift, clamp to int8 (or [0,127] under ReLU).
  always_comb begin
    shifted = prod_q >>> shift;
    if (shifted > PW'(127)) begin
      sat = 8'h7F;
    end else if (relu_en && (shifted < PW'(0))) begin
      sat = '0;
    end else if (shifted < -PW'(128)) begin
      sat = 8'h80;
    end else begin
      sat = shifted[DATA_W-1:0];
    end
    ofm_d = ofm_q;
    if (quant_out) begin
      ofm_d = pe_en ? sat : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      prod_q <= '0;
      ofm_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      prod_q <= prod_d;
      ofm_q  <= ofm_d;
    end
  end

  assign ofm = ofm_q;

endmodule

// File: rtl/pe_cluster_v3.sv
// Cluster of NUM_PE int8 PEs sharing one IFM beat: job FSM, beat counter and
// latched configuration live here; per-PE datapath lives in quad_pe_v3.
module pe_cluster_v3
  import pe_pkg::*;
#(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                clear,
  input  logic [LEN_W-1:0]    acc_len,
  input  logic [COEF_W-1:0]   coef,
  input  logic [SHIFT_W-1:0]  shift,
  input  logic                relu_en,
  input  logic [NUM_PE-1:0]   pe_en,
  pe_cluster_v3_if.slave      bus,
  output logic                busy,
  output logic                done
);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [COEF_W-1:0]    coef_q, coef_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic [NUM_PE-1:0]    pe_en_q, pe_en_d;
  logic                 quant_phase_q, quant_phase_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LEN_W:0]       cnt_inc, eff_len;
  logic                 acc_clr, acc_en, quant_mul, quant_out;
  logic [NUM_PE*DATA_W-1:0] ofm_w;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    coef_d        = coef_q;
    shift_d       = shift_q;
    relu_d        = relu_q;
    pe_en_d       = pe_en_q;
    quant_phase_d = quant_phase_q;
    done_d        = 1'b0;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;
    quant_mul     = 1'b0;
    quant_out     = 1'b0;
    cnt_inc       = {1'b0, cnt_q} + (LEN_W+1)'(1);
    eff_len       = (len_q == '0) ? (LEN_W+1)'(1) : {1'b0, len_q};

    if (clear) begin
      state_d       = ST_IDLE;
      quant_phase_d = 1'b0;
      acc_clr       = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d   = acc_len;
            coef_d  = coef;
            shift_d = shift;
            relu_d  = relu_en;
            pe_en_d = pe_en;
            cnt_d   = '0;
            acc_clr = 1'b1;
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            acc_en = 1'b1;
            cnt_d  = cnt_inc[LEN_W-1:0];
            if (cnt_inc == eff_len) begin
              state_d       = ST_QUANT;
              quant_phase_d = 1'b0;
            end
          end
        end
        // QUANT spans two cycles: multiply/round, then shift/saturate/register.
        ST_QUANT: begin
          if (!quant_phase_q) begin
            quant_mul     = 1'b1;
            quant_phase_d = 1'b1;
          end else begin
            quant_out     = 1'b1;
            quant_phase_d = 1'b0;
            state_d       = ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_OUTPUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      coef_q        <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      pe_en_q       <= '0;
      quant_phase_q <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      coef_q        <= coef_d;
      shift_q       <= shift_d;
      relu_q        <= relu_d;
      pe_en_q       <= pe_en_d;
      quant_phase_q <= quant_phase_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  for (genvar gp = 0; gp < NUM_PE; gp++) begin : g_pe
    quad_pe_v3 #(
      .LANES (LANES),
      .ACC_W (ACC_W)
    ) u_pe (
      .clk       (clk),
      .reset_n   (reset_n),
      .acc_clr   (acc_clr),
      .acc_en    (acc_en),
      .quant_mul (quant_mul),
      .quant_out (quant_out),
      .ifm       (bus.ifm),
      .weight    (bus.weight[gp*LANES*DATA_W +: LANES*DATA_W]),
      .coef      (coef_q),
      .shift     (shift_q),
      .relu_en   (relu_q),
      .pe_en     (pe_en_q[gp]),
      .ofm       (ofm_w[gp*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ofm       = ofm_w;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_pe_cluster_v3.sv
// Randomised self-checking bench for pe_cluster_v3 against a plain-arithmetic
// reference model of the dot-product / requantise / saturate rules.
module tb_pe_cluster_v3;

  localparam int unsigned NUM_PE = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned LEN_W  = 12;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              clear   = 1'b0;
  logic [LEN_W-1:0]  acc_len = '0;
  logic [7:0]        coef    = '0;
  logic [4:0]        shift   = '0;
  logic              relu_en = 1'b0;
  logic [15:0]       pe_en   = '0;
  logic              busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [31:0]  beat_ifm [8];
  logic [511:0] beat_w   [8];
  int           vpat [$];

  pe_cluster_v3_if #(.NUM_PE(NUM_PE), .LANES(LANES)) bus ();

  pe_cluster_v3 #(
    .NUM_PE (NUM_PE),
    .LANES  (LANES),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .clear   (clear),
    .acc_len (acc_len),
    .coef    (coef),
    .shift   (shift),
    .relu_en (relu_en),
    .pe_en   (pe_en),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input int unsigned n, input logic [7:0] c,
                                         input logic [4:0] s, input logic r,
                                         input logic [15:0] en);
    logic [127:0]     res;
    longint           acc, v;
    logic signed [7:0] a, w;
    res = '0;
    for (int p = 0; p < 16; p++) begin
      acc = 0;
      for (int bi = 0; bi < int'(n); bi++) begin
        for (int l = 0; l < 4; l++) begin
          a = beat_ifm[bi][8*l +: 8];
          w = beat_w[bi][(p*4+l)*8 +: 8];
          acc += longint'(a) * longint'(w);
        end
      end
      acc = longint'(int'(acc));
      v = acc * longint'(c);
      if (s != 0) v += longint'(1) << (s - 1);
      v = v >>> s;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      if (r && v < 0) v = 0;
      if (en[p]) res[p*8 +: 8] = v[7:0];
    end
    return res;
  endfunction

  task automatic fill_random();
    for (int bi = 0; bi < 8; bi++) begin
      beat_ifm[bi] = $urandom;
      for (int p = 0; p < 16; p++) beat_w[bi][p*32 +: 32] = $urandom;
    end
  endtask

  // Called at a negedge; start is seen by the following posedge.
  task automatic start_job(input logic [LEN_W-1:0] len, input logic [7:0] c,
                           input logic [4:0] s, input logic r, input logic [15:0] en);
    acc_len = len; coef = c; shift = s; relu_en = r; pe_en = en; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    acc_len = LEN_W'($urandom);
    coef    = 8'($urandom);
    shift   = 5'($urandom);
    relu_en = 1'($urandom);
    pe_en   = 16'($urandom);
  endtask

  task automatic feed(input int unsigned n, output int unsigned got);
    int unsigned cyc;
    logic v, acc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 100) begin
      if (vpat.size() > 0) v = (vpat.pop_front() != 0);
      else v = ($urandom_range(0, 3) != 0);
      bus.in_valid = v;
      if (v) begin
        bus.ifm    = beat_ifm[got];
        bus.weight = beat_w[got];
      end else begin
        bus.ifm = $urandom;
        for (int p = 0; p < 16; p++) bus.weight[p*32 +: 32] = $urandom;
      end
      start = ($urandom_range(0, 7) == 0);
      acc = v && (bus.in_ready === 1'b1);
      @(negedge clk);
      cyc++;
      if (acc) got++;
    end
    start = 1'b0;
    bus.ifm = $urandom;
    if (got < n) check("beat_timeout", 128'(got), 128'(n));
  endtask

  // Entered at the negedge right after the edge that accepted the last beat.
  task automatic finish_job(input string tag, input logic [127:0] exp, input int unsigned hold);
    logic [127:0] held;
    int           d0;
    bit           stable;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_ov_early"}, 128'(bus.out_valid), 128'(0));
    @(negedge clk);
    check({tag, "_ov_rise"}, 128'(bus.out_valid), 128'(1));
    check({tag, "_ofm"}, bus.ofm, exp);
    held   = bus.ofm;
    stable = 1'b1;
    d0     = done_cnt;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.ofm !== held || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_stall"}, 128'(stable), 128'(1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_done"}, 128'({done, bus.out_valid, busy}), 128'(3'b100));
    @(negedge clk);
    check({tag, "_done_once"}, 128'({done, 8'(done_cnt - d0)}), 128'({1'b0, 8'd1}));
  endtask

  task automatic run_job(input string tag, input logic [LEN_W-1:0] len, input logic [7:0] c,
                         input logic [4:0] s, input logic r, input logic [15:0] en,
                         input int unsigned hold);
    int unsigned  n, got;
    logic [127:0] exp;
    n   = (len == '0) ? 1 : int'(len);
    exp = model(n, c, s, r, en);
    start_job(len, c, s, r, en);
    feed(n, got);
    finish_job(tag, exp, hold);
  endtask

  initial begin
    int unsigned  got, d0;
    logic [127:0] held;
    bus.in_valid  = 1'b0;
    bus.ifm       = '0;
    bus.weight    = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ctrl", 128'({bus.in_ready, bus.out_valid, busy, done}), 128'(0));
    check("rst_ofm", bus.ofm, 128'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 128'({busy, bus.in_ready}), 128'(0));

    // Single beat, PE0 weights 2, ifm 1 -> 8
    for (int bi = 0; bi < 8; bi++) begin beat_ifm[bi] = '0; beat_w[bi] = '0; end
    beat_ifm[0] = {4{8'd1}};
    beat_w[0][31:0] = {4{8'd2}};
    run_job("unit", 12'd1, 8'd1, 5'd0, 1'b0, 16'hFFFF, 0);
    check("unit_pe0", 128'(bus.ofm[7:0]), 128'(8));

    // Maximum products saturate high
    for (int bi = 0; bi < 8; bi++) begin beat_ifm[bi] = {4{8'd127}}; beat_w[bi] = {64{8'd127}}; end
    run_job("sat", 12'd4, 8'd1, 5'd0, 1'b0, 16'hFFFF, 1);
    check("sat_all", bus.ofm, {16{8'h7F}});

    // acc = -80, coef 3, shift 2 -> -60; ReLU -> 0
    for (int bi = 0; bi < 8; bi++) begin beat_ifm[bi] = {4{8'd10}}; beat_w[bi] = {64{8'hFF}}; end
    run_job("neg", 12'd2, 8'd3, 5'd2, 1'b0, 16'hFFFF, 0);
    check("neg_pe0", 128'(bus.ofm[7:0]), 128'(8'hC4));
    run_job("relu", 12'd2, 8'd3, 5'd2, 1'b1, 16'hFFFF, 0);
    check("relu_all", bus.ofm, 128'(0));

    // acc = 5, shift 1 rounds half up to 3; only PE0 enabled
    for (int bi = 0; bi < 8; bi++) begin beat_ifm[bi] = 32'h0000_0005; beat_w[bi] = {16{32'h0000_0001}}; end
    run_job("round", 12'd1, 8'd1, 5'd1, 1'b0, 16'h0001, 0);
    check("round_ofm", bus.ofm, 128'h03);

    // Gapped in_valid 1,0,1,1 with three beats, result held for five cycles
    fill_random();
    vpat = '{1, 0, 1, 1};
    run_job("gap", 12'd3, 8'd5, 5'd6, 1'b0, 16'hFFFF, 5);

    // Reset mid-job, then restart on the first edge after release
    fill_random();
    start_job(12'd4, 8'd7, 5'd4, 1'b0, 16'hFFFF);
    feed(2, got);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ctrl", 128'({busy, bus.in_ready, bus.out_valid, done}), 128'(0));
    check("midrst_ofm", bus.ofm, 128'(0));
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    check("midrst_nodone", 128'(done_cnt - d0), 128'(0));
    reset_n = 1'b1;
    fill_random();
    run_job("after_rst", 12'd4, 8'd7, 5'd4, 1'b0, 16'hFFFF, 0);

    // Clear mid-job: ofm untouched, no done, next job starts from zero
    held = bus.ofm;
    fill_random();
    start_job(12'd4, 8'd9, 5'd5, 1'b0, 16'hFFFF);
    feed(2, got);
    d0 = done_cnt;
    clear = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_idle", 128'({busy, bus.in_ready, bus.out_valid}), 128'(0));
    check("clr_ofm", bus.ofm, held);
    // clear beats start in IDLE
    clear = 1'b1; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    check("clr_start", 128'({busy, bus.in_ready, 8'(done_cnt - d0)}), 128'(0));
    fill_random();
    run_job("after_clr", 12'd4, 8'd9, 5'd5, 1'b0, 16'hFFFF, 0);

    // Randomised jobs, first one exercising acc_len = 0
    for (int j = 0; j < 24; j++) begin
      fill_random();
      run_job($sformatf("rnd%0d", j),
              (j == 0) ? 12'd0 : 12'($urandom_range(0, 6)),
              8'($urandom), 5'($urandom_range(0, 20)), 1'($urandom),
              (j % 3 == 0) ? 16'hFFFF : 16'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
